// File: rtl/m3_serial_tx.sv
// m3_serial_tx: MSB-first serial word transmitter with a free-running
// slow clock and a running mod-3 remainder of the bits sent.
module m3_serial_tx #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             busy,
  output logic             sout,
  output logic             bit_valid,
  output logic             slo_clk,
  output logic [1:0]       rem,
  output logic             done,
  output logic             mult3
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             slo_q, slo_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             sout_q, sout_d;
  logic             bv_q, bv_d;
  logic [1:0]       rem_q, rem_d;
  logic             done_q, done_d;
  logic             m3_q, m3_d;
  logic             tick;

  // Appending bit b to a value v: (2*v + b) mod 3.
  function automatic logic [1:0] rem_step(
    input logic [1:0] r,
    input logic       b
  );
    logic [1:0] n;
    case ({r, b})
      3'b000:  n = 2'd0;
      3'b001:  n = 2'd1;
      3'b010:  n = 2'd2;
      3'b011:  n = 2'd0;
      3'b100:  n = 2'd1;
      3'b101:  n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

  always_comb begin
    tick  = (cnt_q == CW'(DIV - 1));
    cnt_d = tick ? '0 : cnt_q + CW'(1);
    slo_d = (cnt_d >= CW'(DIV / 2));
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    sout_d  = sout_q;
    bv_d    = bv_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    m3_d    = m3_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d = din;
          rem_d   = 2'd0;
          m3_d    = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (tick) begin
          sout_d  = shreg_q[WIDTH-1];
          bv_d    = 1'b1;
          rem_d   = rem_step(rem_q, shreg_q[WIDTH-1]);
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          idx_d   = IW'(WIDTH - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (idx_q == '0) begin
            sout_d  = 1'b0;
            bv_d    = 1'b0;
            done_d  = 1'b1;
            m3_d    = (rem_q == 2'd0);
            state_d = IDLE;
          end else begin
            sout_d  = shreg_q[WIDTH-1];
            rem_d   = rem_step(rem_q, shreg_q[WIDTH-1]);
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            idx_d   = idx_q - IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      slo_q   <= 1'b0;
      shreg_q <= '0;
      idx_q   <= '0;
      sout_q  <= 1'b0;
      bv_q    <= 1'b0;
      rem_q   <= 2'd0;
      done_q  <= 1'b0;
      m3_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slo_q   <= slo_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      sout_q  <= sout_d;
      bv_q    <= bv_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      m3_q    <= m3_d;
    end
  end

  assign ready     = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign sout      = sout_q;
  assign bit_valid = bv_q;
  assign slo_clk   = slo_q;
  assign rem       = rem_q;
  assign done      = done_q;
  assign mult3     = m3_q;

endmodule

// File: tb/tb_m3_serial_tx.sv
// tb_m3_serial_tx: randomized bench for m3_serial_tx against a
// frame-schedule model computed from cycle arithmetic.
module tb_m3_serial_tx;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] din;
  logic         ready;
  logic         busy;
  logic         sout;
  logic         bit_valid;
  logic         slo_clk;
  logic [1:0]   rem;
  logic         done;
  logic         mult3;

  m3_serial_tx #(.WIDTH(W), .DIV(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .din       (din),
    .ready     (ready),
    .busy      (busy),
    .sout      (sout),
    .bit_valid (bit_valid),
    .slo_clk   (slo_clk),
    .rem       (rem),
    .done      (done),
    .mult3     (mult3)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // model state: cycle index, divider origin, current frame schedule
  int cyc    = 0;
  int base   = 0;
  bit in_fr  = 0;
  int f_bit  = 0;
  int f_end  = 0;
  int dl     = 0;
  int irem   = 0;
  int im3    = 0;
  bit chk_en = 0;

  // observations for literal checks
  int           bvc   = 0;
  int           donec = 0;
  logic [W-1:0] sbits = '0;
  logic [15:0]  rseq  = '0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
  endtask

  task automatic clr();
    bvc   = 0;
    donec = 0;
    sbits = '0;
    rseq  = '0;
  endtask

  task automatic step(input logic r, input logic s,
                      input logic [W-1:0] d);
    int cnt, k, e;
    int e_rdy, e_busy, e_sout, e_bv, e_rem, e_done, e_m3;
    reset = r;
    start = s;
    din   = d;
    cnt   = (cyc - base) % D;
    e_rdy = 1; e_busy = 0; e_sout = 0; e_bv = 0;
    e_done = 0; e_rem = irem; e_m3 = im3;
    if (in_fr) begin
      if (cyc == f_end) begin
        e_done = 1;
        e_rem  = dl % 3;
        e_m3   = (dl % 3 == 0) ? 1 : 0;
      end else begin
        e_rdy = 0; e_busy = 1; e_rem = 0; e_m3 = 0;
        if (cyc >= f_bit) begin
          k      = (cyc - f_bit) / D;
          e_sout = (dl >> (W - 1 - k)) & 1;
          e_bv   = 1;
          e_rem  = (dl >> (W - 1 - k)) % 3;
        end
      end
    end
    if (chk_en) begin
      chk("ready",     32'(ready),     32'(e_rdy));
      chk("busy",      32'(busy),      32'(e_busy));
      chk("sout",      32'(sout),      32'(e_sout));
      chk("bit_valid", 32'(bit_valid), 32'(e_bv));
      chk("rem",       32'(rem),       32'(e_rem));
      chk("done",      32'(done),      32'(e_done));
      chk("mult3",     32'(mult3),     32'(e_m3));
      chk("slo_clk",   32'(slo_clk),   32'((cnt >= D / 2) ? 1 : 0));
    end
    if (bit_valid === 1'b1) begin
      if (bvc % D == 0) begin
        sbits = {sbits[W-2:0], sout};
        rseq  = {rseq[13:0], rem};
      end
      bvc++;
    end
    if (done === 1'b1) donec++;
    if (r) begin
      base = cyc + 1; in_fr = 0; irem = 0; im3 = 0; chk_en = 1;
    end else if (e_rdy == 1 && s) begin
      in_fr = 1;
      dl    = int'(d);
      e     = cyc + 1;
      while ((e - base) % D != D - 1) e++;
      f_bit = e + 1;
      f_end = f_bit + W * D;
    end else if (in_fr && cyc == f_end) begin
      in_fr = 0;
      irem  = dl % 3;
      im3   = (dl % 3 == 0) ? 1 : 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_frame(input logic [W-1:0] d, input bit poke);
    int n;
    clr();
    step(1'b0, 1'b1, d);
    n = 0;
    while (donec == 0 && n < 200) begin
      step(1'b0, poke && (n == 10), poke ? 8'hAA : W'($urandom));
      n++;
    end
    if (donec == 0) begin
      n_chk++;
      $display("FAIL frame_timeout: got no done expected done");
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    din   = '0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, '0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_sout",  32'(sout),  32'd0);
    chk("rst_mult3", 32'(mult3), 32'd0);
    repeat (3) step(1'b0, 1'b0, '0);

    run_frame(8'h06, 1'b1);
    chk("f06_bits",  32'(sbits), 32'h06);
    chk("f06_rems",  32'(rseq),  32'h0010);
    chk("f06_bvc",   32'(bvc),   32'd32);
    chk("f06_donec", 32'(donec), 32'd1);
    chk("f06_mult3", 32'(mult3), 32'd1);

    run_frame(8'h07, 1'b0);
    chk("f07_rem",   32'(rem),   32'd1);
    chk("f07_mult3", 32'(mult3), 32'd0);
    chk("f07_bvc",   32'(bvc),   32'd32);

    run_frame(8'hFF, 1'b0);
    chk("fff_rems",  32'(rseq),  32'h4444);
    chk("fff_mult3", 32'(mult3), 32'd1);

    clr();
    step(1'b0, 1'b1, 8'h35);
    n = 0;
    while (bvc < 13 && n < 200) begin
      step(1'b0, 1'b0, '0);
      n++;
    end
    chk("mid_sout_before", 32'(bit_valid), 32'd1);
    step(1'b1, 1'b0, '0);
    chk("mid_sout",  32'(sout),      32'd0);
    chk("mid_bv",    32'(bit_valid), 32'd0);
    chk("mid_ready", 32'(ready),     32'd1);
    chk("mid_rem",   32'(rem),       32'd0);
    chk("mid_slo",   32'(slo_clk),   32'd0);
    chk("mid_donec", 32'(donec),     32'd0);
    run_frame(8'h09, 1'b0);
    chk("f09_mult3", 32'(mult3), 32'd1);

    step(1'b0, 1'b1, 8'h06);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      step(1'b0, 1'b0, '0);
      n++;
    end
    chk("b2b_done_seen", 32'(done), 32'd1);
    step(1'b0, 1'b1, 8'h0A);
    chk("b2b_accept", 32'(ready), 32'd0);
    clr();
    n = 0;
    while (donec == 0 && n < 200) begin
      step(1'b0, 1'b0, W'($urandom));
      n++;
    end
    chk("f0a_rem",   32'(rem),   32'd1);
    chk("f0a_mult3", 32'(mult3), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 300) == 0, ($urandom % 4) == 0, W'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
